tpu_ctrl_datapath: RTL and testbench
====================================

// Module: tpu_ctrl_datapath
// PURPOSE
//  Control/feed/collect slice of the 2x2 systolic TPU; sits between the instruction sequencer and the MMU/unified buffer.
//  Decodes 16-bit instructions into address and strobes, skews a 2x2 activation matrix into the MMU rows,
//  and captures the two MMU column outputs into two 2-word result stores with "full" flags for the unified buffer.
// PARAMETERS
//  ACC1_LAT  3  valid-step index at which column-1 result word 0 is captured
//  ACC2_LAT  4  valid-step index at which column-2 result word 0 is captured (one extra for column skew)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   reset, asynchronous, active-low
//  instruction  in   16  [15:13] opcode, [12:0] operand
//  a11,a12,a21,a22 in 32 activation matrix from unified buffer; low 16 bits used
//  acc_in1      in   32  MMU column-1 partial-sum output
//  acc_in2      in   32  MMU column-2 partial-sum output
//  base_address out  13  latched address for weight memory / unified buffer
//  load_weight  out  1   weight-load strobe to MMU
//  load_input   out  1   input-load strobe to unified buffer
//  valid        out  1   compute-active flag
//  store        out  1   store strobe to unified buffer
//  a_in1,a_in2  out  16  skewed activations into MMU rows 1 and 2
//  acc1_mem_0,acc1_mem_1,acc2_mem_0,acc2_mem_1 out 32 captured result words
//  acc1_full,acc2_full out 1 result store complete
// BEHAVIOUR
//  Reset (reset=0, any time, async): every output and internal register = 0; step counters = 0.
//  Decode (registered, 1-cycle latency): at each edge, from instruction:
//   000 NOP: all strobes 0. 001 LOAD_ADDR: base_address<=operand. 010 LOAD_WEIGHT: load_weight=1.
//   011 LOAD_INPUT: load_input=1. 100 COMPUTE: valid=1. 101 STORE: store=1. 110/111: treated as NOP.
//   Strobes are 1 only for the cycle after the matching instruction; held instruction keeps strobe high.
//   base_address holds until next LOAD_ADDR; other opcodes never change it.
//  Step counter: counts edges while valid=1 (step 0 = first edge with valid=1); saturates at 7; cleared to 0 on an edge with valid=0.
//  Input skew (registered), per step with valid=1:
//   step0: (a_in1,a_in2)=(a11,0); step1: (a21,a12); step2: (0,a22); step>=3: (0,0).
//   valid=0: both outputs 0. Inputs sampled live each step (truncate [31:16]).
//  Accumulators (per column n, latency L=ACCn_LAT), valid=1:
//   step L: accn_mem_0<=acc_inn; step L+1: accn_mem_1<=acc_inn and accn_full<=1.
//   Capture overwrites (no summing). full stays 1 while valid=1; clears on first edge with valid=0.
//   Mem words hold until reset or next capture. If valid drops before step L+1, full never sets and
//   only words already captured change.
//  Back-to-back COMPUTE without an intervening non-COMPUTE cycle = one continuous compute (counter not restarted).
//  Reset mid-compute: everything cleared; next COMPUTE starts at step 0.
// TESTING
//  1. reset low, then instr 001_0000000001111 -> next cycle base_address=0x000F, all strobes 0.
//  2. instr 010/011/101 one cycle each -> load_weight, load_input, store each high exactly one cycle, 1-cycle delay.
//  3. a11=1,a12=2,a21=3,a22=4, COMPUTE 6 cycles -> a_in1/a_in2 = (1,0),(3,2),(0,4),(0,0)...
//  4. Same compute, acc_in1=10 at step3 and 20 at step4, acc_in2=30 at step4 and 40 at step5
//     -> acc1_mem=10/20 with full at step4, acc2_mem=30/40 with full at step5; both fulls clear after valid drops.
//  5. COMPUTE for 3 cycles only -> no full asserted; mem words unchanged (acc1_mem_0 from step3 only if reached).
//  6. reset asserted during step2 -> all outputs 0 immediately; a new COMPUTE restarts skew at (a11,0).

Source files
------------

// File: rtl/tpu_ctrl_datapath.sv
// Control/feed/collect slice of the 2x2 systolic TPU.
// Decodes 16-bit instructions into an address and strobes. Skews a 2x2
// activation matrix into the MMU rows. Captures both MMU column outputs
// into 2-word result stores, each with a "full" flag.
module tpu_ctrl_datapath #(
   parameter int unsigned ACC1_LAT = 3,
   parameter int unsigned ACC2_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instruction,
   input  logic [31:0] a11,
   input  logic [31:0] a12,
   input  logic [31:0] a21,
   input  logic [31:0] a22,
   input  logic [31:0] acc_in1,
   input  logic [31:0] acc_in2,
   output logic [12:0] base_address,
   output logic        load_weight,
   output logic        load_input,
   output logic        valid,
   output logic        store,
   output logic [15:0] a_in1,
   output logic [15:0] a_in2,
   output logic [31:0] acc1_mem_0,
   output logic [31:0] acc1_mem_1,
   output logic [31:0] acc2_mem_0,
   output logic [31:0] acc2_mem_1,
   output logic        acc1_full,
   output logic        acc2_full
);

   typedef enum logic [2:0] {
      OP_NOP         = 3'b000,
      OP_LOAD_ADDR   = 3'b001,
      OP_LOAD_WEIGHT = 3'b010,
      OP_LOAD_INPUT  = 3'b011,
      OP_COMPUTE     = 3'b100,
      OP_STORE       = 3'b101
   } opcode_e;

   localparam logic [2:0] LP_STEP_MAX = 3'd7;
   localparam logic [2:0] LP_A1_W0    = 3'(ACC1_LAT);
   localparam logic [2:0] LP_A1_W1    = 3'(ACC1_LAT + 1);
   localparam logic [2:0] LP_A2_W0    = 3'(ACC2_LAT);
   localparam logic [2:0] LP_A2_W1    = 3'(ACC2_LAT + 1);

   opcode_e     w_op;
   logic        w_unused_hi;

   logic [12:0] r_base;
   logic        r_load_weight;
   logic        r_load_input;
   logic        r_valid;
   logic        r_store;
   logic [2:0]  r_step;
   logic [15:0] r_a_in1;
   logic [15:0] r_a_in2;
   logic [31:0] r_acc1_mem_0;
   logic [31:0] r_acc1_mem_1;
   logic [31:0] r_acc2_mem_0;
   logic [31:0] r_acc2_mem_1;
   logic        r_acc1_full;
   logic        r_acc2_full;

   // Opcodes 110/111 fall through to NOP behaviour in the decode below.
   assign w_op = opcode_e'(instruction[15:13]);

   // Only the low half of each activation word feeds the MMU.
   assign w_unused_hi = ^{a11[31:16], a12[31:16], a21[31:16], a22[31:16]};

   // Registered instruction decode: strobes follow the opcode by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_base        <= '0;
         r_load_weight <= 1'b0;
         r_load_input  <= 1'b0;
         r_valid       <= 1'b0;
         r_store       <= 1'b0;
      end else begin
         r_load_weight <= (w_op == OP_LOAD_WEIGHT);
         r_load_input  <= (w_op == OP_LOAD_INPUT);
         r_valid       <= (w_op == OP_COMPUTE);
         r_store       <= (w_op == OP_STORE);
         if (w_op == OP_LOAD_ADDR) begin
            r_base <= instruction[12:0];
         end
      end
   end

   // Step counter (saturating) and diagonal skew of the activation matrix.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_step  <= '0;
         r_a_in1 <= '0;
         r_a_in2 <= '0;
      end else if (r_valid) begin
         if (r_step != LP_STEP_MAX) begin
            r_step <= r_step + 3'd1;
         end
         case (r_step)
            3'd0: begin
               r_a_in1 <= a11[15:0];
               r_a_in2 <= '0;
            end
            3'd1: begin
               r_a_in1 <= a21[15:0];
               r_a_in2 <= a12[15:0];
            end
            3'd2: begin
               r_a_in1 <= '0;
               r_a_in2 <= a22[15:0];
            end
            default: begin
               r_a_in1 <= '0;
               r_a_in2 <= '0;
            end
         endcase
      end else begin
         r_step  <= '0;
         r_a_in1 <= '0;
         r_a_in2 <= '0;
      end
   end

   // Result capture: each column grabs two consecutive words at its latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc1_mem_0 <= '0;
         r_acc1_mem_1 <= '0;
         r_acc2_mem_0 <= '0;
         r_acc2_mem_1 <= '0;
         r_acc1_full  <= 1'b0;
         r_acc2_full  <= 1'b0;
      end else if (r_valid) begin
         if (r_step == LP_A1_W0) begin
            r_acc1_mem_0 <= acc_in1;
         end
         if (r_step == LP_A1_W1) begin
            r_acc1_mem_1 <= acc_in1;
            r_acc1_full  <= 1'b1;
         end
         if (r_step == LP_A2_W0) begin
            r_acc2_mem_0 <= acc_in2;
         end
         if (r_step == LP_A2_W1) begin
            r_acc2_mem_1 <= acc_in2;
            r_acc2_full  <= 1'b1;
         end
      end else begin
         r_acc1_full <= 1'b0;
         r_acc2_full <= 1'b0;
      end
   end

   assign base_address = r_base;
   assign load_weight  = r_load_weight;
   assign load_input   = r_load_input;
   assign valid        = r_valid;
   assign store        = r_store;
   assign a_in1        = r_a_in1;
   assign a_in2        = r_a_in2;
   assign acc1_mem_0   = r_acc1_mem_0;
   assign acc1_mem_1   = r_acc1_mem_1;
   assign acc2_mem_0   = r_acc2_mem_0;
   assign acc2_mem_1   = r_acc2_mem_1;
   assign acc1_full    = r_acc1_full;
   assign acc2_full    = r_acc2_full;

endmodule

// File: tb/tb_tpu_ctrl_datapath.sv
// Scoreboard bench for tpu_ctrl_datapath: each driven cycle pushes the
// hand-computed post-edge output snapshot; a negedge monitor pops and compares.
module tb_tpu_ctrl_datapath;

   localparam logic [15:0] I_NOP     = 16'h0000;
   localparam logic [15:0] I_COMPUTE = 16'h8000;

   typedef struct {
      logic [12:0] base;
      logic        lw, li, v, st;
      logic [15:0] ain1, ain2;
      logic [31:0] m10, m11, m20, m21;
      logic        f1, f2;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] instruction;
   logic [31:0] a11, a12, a21, a22, acc_in1, acc_in2;
   logic [12:0] base_address;
   logic        load_weight, load_input, valid, store;
   logic [15:0] a_in1, a_in2;
   logic [31:0] acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1;
   logic        acc1_full, acc2_full;

   exp_t e;
   exp_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   tpu_ctrl_datapath #(.ACC1_LAT(3), .ACC2_LAT(4)) dut (
      .clk(clk), .reset(reset), .instruction(instruction),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .acc_in1(acc_in1), .acc_in2(acc_in2),
      .base_address(base_address), .load_weight(load_weight),
      .load_input(load_input), .valid(valid), .store(store),
      .a_in1(a_in1), .a_in2(a_in2),
      .acc1_mem_0(acc1_mem_0), .acc1_mem_1(acc1_mem_1),
      .acc2_mem_0(acc2_mem_0), .acc2_mem_1(acc2_mem_1),
      .acc1_full(acc1_full), .acc2_full(acc2_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic clear_e();
      e.base = '0; e.lw = 1'b0; e.li = 1'b0; e.v = 1'b0; e.st = 1'b0;
      e.ain1 = '0; e.ain2 = '0;
      e.m10 = '0; e.m11 = '0; e.m20 = '0; e.m21 = '0;
      e.f1 = 1'b0; e.f2 = 1'b0;
   endtask

   task automatic set_ain(input logic [15:0] x1, input logic [15:0] x2);
      e.ain1 = x1;
      e.ain2 = x2;
   endtask

   // Drive one instruction across one rising edge; e must already hold the post-edge state.
   task automatic cyc(input logic [15:0] ins);
      instruction = ins;
      @(posedge clk);
      q.push_back(e);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_base"}, 32'(base_address), 32'h0);
      chk({tag, "_strobes"}, {28'h0, load_weight, load_input, valid, store}, 32'h0);
      chk({tag, "_ain1"}, 32'(a_in1), 32'h0);
      chk({tag, "_ain2"}, 32'(a_in2), 32'h0);
      chk({tag, "_m10"}, acc1_mem_0, 32'h0);
      chk({tag, "_m11"}, acc1_mem_1, 32'h0);
      chk({tag, "_m20"}, acc2_mem_0, 32'h0);
      chk({tag, "_m21"}, acc2_mem_1, 32'h0);
      chk({tag, "_full"}, {30'h0, acc1_full, acc2_full}, 32'h0);
   endtask

   // Monitor: compare every presented output against the oldest expected snapshot.
   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("base_address", 32'(base_address), 32'(x.base));
         chk("load_weight", 32'(load_weight), 32'(x.lw));
         chk("load_input", 32'(load_input), 32'(x.li));
         chk("valid", 32'(valid), 32'(x.v));
         chk("store", 32'(store), 32'(x.st));
         chk("a_in1", 32'(a_in1), 32'(x.ain1));
         chk("a_in2", 32'(a_in2), 32'(x.ain2));
         chk("acc1_mem_0", acc1_mem_0, x.m10);
         chk("acc1_mem_1", acc1_mem_1, x.m11);
         chk("acc2_mem_0", acc2_mem_0, x.m20);
         chk("acc2_mem_1", acc2_mem_1, x.m21);
         chk("acc1_full", 32'(acc1_full), 32'(x.f1));
         chk("acc2_full", 32'(acc2_full), 32'(x.f2));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; instruction = I_NOP;
      a11 = '0; a12 = '0; a21 = '0; a22 = '0; acc_in1 = '0; acc_in2 = '0;
      clear_e();
      repeat (2) @(posedge clk);
      #1;
      q.push_back(e);              // reset state, seen at the next negedge
      @(negedge clk);
      #1;
      reset = 1'b1;

      // LOAD_ADDR, then single-cycle strobes; held LOAD_WEIGHT; 110/111 as NOP
      e.base = 13'h000F;                 cyc(16'b001_0000000001111);
      e.lw = 1'b1;                       cyc(16'h4000);
      e.lw = 1'b0; e.li = 1'b1;          cyc(16'h6000);
      e.li = 1'b0; e.st = 1'b1;          cyc(16'hA000);
      e.st = 1'b0;                       cyc(I_NOP);
      e.lw = 1'b1;                       cyc(16'h4000);
      e.lw = 1'b1;                       cyc(16'h4000);
      e.lw = 1'b0;                       cyc(16'hDFFF);
                                         cyc(16'hFFFF);

      // Six-cycle compute: skew and both columns fill
      a11 = 32'hABCD_0001; a12 = 32'h1111_0002; a21 = 32'h2222_0003; a22 = 32'hFFFF_0004;
      acc_in1 = 32'd99; acc_in2 = 32'd88;
      e.v = 1'b1;                        cyc(I_COMPUTE);
      set_ain(16'd1, 16'd0);             cyc(I_COMPUTE);
      set_ain(16'd3, 16'd2);             cyc(I_COMPUTE);
      set_ain(16'd0, 16'd4);             cyc(I_COMPUTE);
      acc_in1 = 32'd10; acc_in2 = 32'd77;
      set_ain(16'd0, 16'd0); e.m10 = 32'd10; cyc(I_COMPUTE);
      acc_in1 = 32'd20; acc_in2 = 32'd30;
      e.m11 = 32'd20; e.f1 = 1'b1; e.m20 = 32'd30; cyc(I_COMPUTE);
      acc_in1 = 32'd55; acc_in2 = 32'd40;
      e.v = 1'b0; e.m21 = 32'd40; e.f2 = 1'b1; cyc(I_NOP);
      acc_in1 = 32'd66; acc_in2 = 32'd66;
      e.f1 = 1'b0; e.f2 = 1'b0;          cyc(I_NOP);
                                         cyc(I_NOP);

      // Three-cycle compute: never reaches a capture step
      a11 = 32'd5; a12 = 32'd6; a21 = 32'd7; a22 = 32'd8;
      acc_in1 = 32'd1234; acc_in2 = 32'd1234;
      e.v = 1'b1;                        cyc(I_COMPUTE);
      set_ain(16'd5, 16'd0);             cyc(I_COMPUTE);
      set_ain(16'd7, 16'd6);             cyc(I_COMPUTE);
      e.v = 1'b0; set_ain(16'd0, 16'd8); cyc(I_NOP);
      set_ain(16'd0, 16'd0);             cyc(I_NOP);

      // Four-cycle compute: only acc1_mem_0 captured, no full
      e.v = 1'b1;                        cyc(I_COMPUTE);
      set_ain(16'd5, 16'd0);             cyc(I_COMPUTE);
      set_ain(16'd7, 16'd6);             cyc(I_COMPUTE);
      set_ain(16'd0, 16'd8);             cyc(I_COMPUTE);
      acc_in1 = 32'd500; acc_in2 = 32'd600;
      e.v = 1'b0; set_ain(16'd0, 16'd0); e.m10 = 32'd500; cyc(I_NOP);
                                         cyc(I_NOP);

      // Ten back-to-back COMPUTEs: counter saturates, no re-skew or recapture
      for (int k = 0; k < 12; k++) begin
         acc_in1 = 32'(100 + k);
         acc_in2 = 32'(200 + k);
         e.v = (k < 10);
         case (k)
            1:       set_ain(16'd5, 16'd0);
            2:       set_ain(16'd7, 16'd6);
            3:       set_ain(16'd0, 16'd8);
            default: set_ain(16'd0, 16'd0);
         endcase
         if (k == 4) e.m10 = 32'd104;
         if (k == 5) begin e.m11 = 32'd105; e.f1 = 1'b1; e.m20 = 32'd205; end
         if (k == 6) begin e.m21 = 32'd206; e.f2 = 1'b1; end
         if (k == 11) begin e.f1 = 1'b0; e.f2 = 1'b0; end
         cyc((k < 10) ? I_COMPUTE : I_NOP);
      end

      // Reset in the middle of a compute, then restart from step 0
      a11 = 32'd1; a12 = 32'd2; a21 = 32'd3; a22 = 32'd4;
      e.v = 1'b1;                        cyc(I_COMPUTE);
      set_ain(16'd1, 16'd0);             cyc(I_COMPUTE);
      set_ain(16'd3, 16'd2);             cyc(I_COMPUTE);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      clear_e();
      instruction = I_COMPUTE;
      @(posedge clk);
      q.push_back(e);
      #1;
      reset = 1'b1;
      e.v = 1'b1;                        cyc(I_COMPUTE);
      set_ain(16'd1, 16'd0);             cyc(I_COMPUTE);
      e.v = 1'b0; set_ain(16'd3, 16'd2); cyc(I_NOP);
      set_ain(16'd0, 16'd0);             cyc(I_NOP);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
      #1;
      n_assert++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
